// File: rtl/lm32_dtlb_assoc.sv
// N-way set-associative data TLB for the LM32 MMU: ASID-tagged entries, global pages,
// store-permission faults and round-robin replacement, one registered-read RAM per way.
module lm32_dtlb_assoc #(
    parameter int dtlb_sets  = 1024,
    parameter int dtlb_ways  = 2,
    parameter int page_size  = 4096,
    parameter int asid_width = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_x,
    input  logic                  stall_m,
    input  logic                  enable_i,
    input  logic [asid_width-1:0] asid_i,
    input  logic [31:0]           address_x,
    input  logic [31:0]           address_m,
    input  logic                  load_q_m,
    input  logic                  store_q_m,
    input  logic                  upd_i,
    input  logic [31:0]           upd_vaddr_i,
    input  logic [31:0]           upd_paddr_i,
    input  logic                  upd_wr_i,
    input  logic                  upd_glb_i,
    input  logic                  flush_i,
    input  logic                  inval_i,
    input  logic [31:0]           inval_vaddr_i,
    output logic [31:0]           physical_address_m,
    output logic                  miss_m,
    output logic                  fault_m,
    output logic [31:0]           miss_addr_o,
    output logic                  busy_o
);

    localparam int OFF_W = $clog2(page_size);
    localparam int IDX_W = $clog2(dtlb_sets);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int PFN_W = 32 - OFF_W;
    localparam int WAY_W = (dtlb_ways > 1) ? $clog2(dtlb_ways) : 1;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [asid_width-1:0] asid;
        logic                  wr;
        logic                  glb;
        logic [PFN_W-1:0]      pfn;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     flush_set_q, flush_set_d;
    logic [WAY_W-1:0]     rr_q, rr_d;
    logic [31:0]          miss_addr_q;
    logic                 rd_ok_q;

    logic [dtlb_ways-1:0] way_we;
    logic [IDX_W-1:0]     waddr;
    entry_t               wdata;
    logic [IDX_W-1:0]     raddr;
    entry_t               rdata [dtlb_ways];
    logic [dtlb_ways-1:0] way_hit;
    logic                 hit_any;
    entry_t               hit_ent;
    logic                 unused_ok;

    assign raddr = address_x[OFF_W +: IDX_W];

    genvar gi;
    generate
        for (gi = 0; gi < dtlb_ways; gi++) begin : g_way
            entry_t mem [dtlb_sets];
            entry_t rd_q;

            // Read and write share one edge, so a same-set update is seen only on the next read.
            always_ff @(posedge clk_i) begin
                if (way_we[gi]) begin
                    mem[waddr] <= wdata;
                end
                if (!stall_m) begin
                    rd_q <= mem[raddr];
                end
            end

            assign rdata[gi]   = rd_q;
            assign way_hit[gi] = rd_ok_q && rd_q.valid
                                 && (rd_q.tag == address_m[31 -: TAG_W])
                                 && (rd_q.glb || (rd_q.asid == asid_i));
        end
    endgenerate

    always_comb begin
        hit_any = 1'b0;
        hit_ent = '0;
        for (int w = dtlb_ways - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_any = 1'b1;
                hit_ent = rdata[w];
            end
        end
        if (state_q == S_FLUSH) begin
            hit_any = 1'b0;
        end
    end

    assign miss_m  = rst_n_i && enable_i && (load_q_m || store_q_m) && !hit_any;
    assign fault_m = rst_n_i && enable_i && store_q_m && hit_any && !hit_ent.wr;
    assign physical_address_m = (enable_i && hit_any) ? {hit_ent.pfn, address_m[OFF_W-1:0]}
                                                      : address_m;
    assign miss_addr_o = miss_addr_q;
    assign busy_o      = (state_q == S_FLUSH);

    always_comb begin
        state_d     = state_q;
        flush_set_d = flush_set_q;
        rr_d        = rr_q;
        way_we      = '0;
        waddr       = raddr;
        wdata       = '0;
        case (state_q)
            S_FLUSH: begin
                way_we = '1;
                waddr  = flush_set_q;
                if (flush_set_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_set_d = flush_set_q - IDX_W'(1);
                end
            end
            default: begin
                if (flush_i) begin
                    state_d     = S_FLUSH;
                    flush_set_d = IDX_W'(dtlb_sets - 1);
                end else if (inval_i) begin
                    way_we = '1;
                    waddr  = inval_vaddr_i[OFF_W +: IDX_W];
                end else if (upd_i) begin
                    way_we[rr_q] = 1'b1;
                    waddr        = upd_vaddr_i[OFF_W +: IDX_W];
                    wdata.valid  = 1'b1;
                    wdata.tag    = upd_vaddr_i[31 -: TAG_W];
                    wdata.asid   = asid_i;
                    wdata.wr     = upd_wr_i;
                    wdata.glb    = upd_glb_i;
                    wdata.pfn    = upd_paddr_i[31:OFF_W];
                    rr_d = (rr_q == WAY_W'(dtlb_ways - 1)) ? '0 : rr_q + WAY_W'(1);
                end
            end
        endcase
        if (!rst_n_i) begin
            way_we = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_FLUSH;
            flush_set_q <= IDX_W'(dtlb_sets - 1);
            rr_q        <= '0;
            miss_addr_q <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_set_q <= flush_set_d;
            rr_q        <= rr_d;
            if ((miss_m || fault_m) && !stall_m) begin
                miss_addr_q <= address_m;
            end
            // Data read while flushing may predate the flush; never let it hit afterwards.
            if (!stall_m) begin
                rd_ok_q <= (state_q == S_IDLE);
            end else if (state_q == S_FLUSH) begin
                rd_ok_q <= 1'b0;
            end
        end
    end

    assign unused_ok = ^{stall_x,
                         address_x[31:OFF_W+IDX_W], address_x[OFF_W-1:0],
                         inval_vaddr_i[31:OFF_W+IDX_W], inval_vaddr_i[OFF_W-1:0],
                         upd_vaddr_i[OFF_W-1:0], upd_paddr_i[OFF_W-1:0]};

endmodule

// File: tb/tb_lm32_dtlb_assoc.sv
// Bench for lm32_dtlb_assoc: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against an entry-table model of the TLB.
module tb_lm32_dtlb_assoc;

    localparam int SETS = 1024;
    localparam int WAYS = 2;
    localparam int PAGE = 4096;
    localparam int OFF  = $clog2(PAGE);
    localparam int IDX  = $clog2(SETS);

    logic        clk_i = 1'b0;
    logic        rst_n_i, stall_x, stall_m, enable_i;
    logic [7:0]  asid_i;
    logic [31:0] address_x, address_m;
    logic        load_q_m, store_q_m, upd_i, upd_wr_i, upd_glb_i, flush_i, inval_i;
    logic [31:0] upd_vaddr_i, upd_paddr_i, inval_vaddr_i;
    logic [31:0] physical_address_m, miss_addr_o;
    logic        miss_m, fault_m, busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    lm32_dtlb_assoc #(.dtlb_sets(SETS), .dtlb_ways(WAYS), .page_size(PAGE), .asid_width(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_x(stall_x), .stall_m(stall_m),
        .enable_i(enable_i), .asid_i(asid_i), .address_x(address_x), .address_m(address_m),
        .load_q_m(load_q_m), .store_q_m(store_q_m), .upd_i(upd_i), .upd_vaddr_i(upd_vaddr_i),
        .upd_paddr_i(upd_paddr_i), .upd_wr_i(upd_wr_i), .upd_glb_i(upd_glb_i),
        .flush_i(flush_i), .inval_i(inval_i), .inval_vaddr_i(inval_vaddr_i),
        .physical_address_m(physical_address_m), .miss_m(miss_m), .fault_m(fault_m),
        .miss_addr_o(miss_addr_o), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        int unsigned tag;
        int unsigned asid;
        bit          wr;
        bit          glb;
        int unsigned pfn;
    } ent_t;

    ent_t        tlb [WAYS][SETS];
    ent_t        held [WAYS];
    bit          held_ok = 0;
    int          flush_left = 0;
    int          rr = 0;
    logic [31:0] m_miss_addr = 0;
    bit          model_live = 0;

    function automatic int unsigned set_of(input logic [31:0] a);
        return (a >> OFF) % SETS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> (OFF + IDX);
    endfunction

    function automatic void clear_all();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) tlb[w][s].v = 0;
    endfunction

    function automatic void model_out(output bit e_miss, output bit e_fault, output logic [31:0] e_phys);
        bit   hit = 0;
        ent_t sel = '{default: 0};
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && held_ok && flush_left == 0 && held[w].v && held[w].tag == tag_of(address_m)
                && (held[w].glb || held[w].asid == asid_i)) begin
                hit = 1;
                sel = held[w];
            end
        end
        e_miss  = enable_i && (load_q_m || store_q_m) && !hit;
        e_fault = enable_i && store_q_m && hit && !sel.wr;
        e_phys  = (enable_i && hit) ? ((sel.pfn << OFF) | (address_m % PAGE)) : address_m;
    endfunction

    initial begin
        bit          em, ef;
        logic [31:0] ep;
        forever begin
            @(posedge clk_i);
            if (!rst_n_i) begin
                model_live  = 1;
                flush_left  = SETS;
                rr          = 0;
                m_miss_addr = 0;
                held_ok     = 0;
                clear_all();
            end else begin
                model_out(em, ef, ep);
                if ((em || ef) && !stall_m) m_miss_addr = address_m;
                if (!stall_m) begin
                    for (int w = 0; w < WAYS; w++) held[w] = tlb[w][set_of(address_x)];
                    held_ok = (flush_left == 0);
                end else if (flush_left > 0) begin
                    held_ok = 0;
                end
                if (flush_left > 0) begin
                    flush_left--;
                end else if (flush_i) begin
                    flush_left = SETS;
                    clear_all();
                end else if (inval_i) begin
                    for (int w = 0; w < WAYS; w++) tlb[w][set_of(inval_vaddr_i)].v = 0;
                end else if (upd_i) begin
                    tlb[rr][set_of(upd_vaddr_i)] = '{1, tag_of(upd_vaddr_i), asid_i, upd_wr_i,
                                                    upd_glb_i, upd_paddr_i >> OFF};
                    rr = (rr + 1) % WAYS;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    initial begin
        bit          em, ef;
        logic [31:0] ep;
        forever begin
            @(negedge clk_i);
            if (model_live) begin
                if (!rst_n_i) begin
                    check("rst_miss", miss_m, 0);
                    check("rst_fault", fault_m, 0);
                    check("rst_busy", busy_o, 1);
                end else begin
                    model_out(em, ef, ep);
                    check("busy", busy_o, flush_left > 0);
                    check("miss", miss_m, em);
                    check("fault", fault_m, ef);
                    check("phys", physical_address_m, ep);
                    check("miss_addr", miss_addr_o, m_miss_addr);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] va, input logic [31:0] pa, input logic [7:0] asid,
                       input logic wr, input logic glb);
        upd_i = 1; upd_vaddr_i = va; upd_paddr_i = pa; asid_i = asid; upd_wr_i = wr; upd_glb_i = glb;
        tick();
        upd_i = 0;
    endtask

    task automatic inval(input logic [31:0] va);
        inval_i = 1; inval_vaddr_i = va;
        tick();
        inval_i = 0;
    endtask

    task automatic access(input logic [31:0] a, input logic ld, input logic st, input logic [7:0] asid,
                          output logic [31:0] pa, output logic mi, output logic fa);
        address_x = a; address_m = a; load_q_m = ld; store_q_m = st; asid_i = asid;
        tick();
        @(negedge clk_i);
        pa = physical_address_m; mi = miss_m; fa = fault_m;
        tick();
        load_q_m = 0; store_q_m = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 3000) begin
            tick();
            n++;
        end
        check("flush_timeout", busy_o, 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] pa;
        logic        mi, fa;
        int          cnt;

        rst_n_i = 0; stall_x = 0; stall_m = 0; enable_i = 1; asid_i = 0;
        address_x = 32'h0000_1000; address_m = 32'h0000_1000; load_q_m = 1; store_q_m = 0;
        upd_i = 0; upd_vaddr_i = 0; upd_paddr_i = 0; upd_wr_i = 0; upd_glb_i = 0;
        flush_i = 0; inval_i = 0; inval_vaddr_i = 0;

        tick();
        @(negedge clk_i);
        check("reset_miss_lit", miss_m, 0);
        tick();
        rst_n_i = 1;

        cnt = 0;
        while (cnt < 3000) begin
            @(negedge clk_i);
            if (!busy_o) break;
            cnt++;
            if (cnt == 5) check("flush_load_miss_lit", miss_m, 1);
        end
        check("busy_cycles_lit", cnt, SETS);
        check("post_flush_miss_lit", miss_m, 1);
        tick();
        check("miss_addr_lit", miss_addr_o, 32'h0000_1000);
        load_q_m = 0;
        tick();

        // Replacement: rr starts at 0, third update lands in way 0.
        upd(32'h0000_3000, 32'hA000_0000, 8'd3, 1, 0);
        upd(32'h0040_3000, 32'hA000_1000, 8'd3, 1, 0);
        upd(32'h0080_3000, 32'hA000_2000, 8'd3, 1, 0);
        access(32'h0000_3010, 1, 0, 8'd3, pa, mi, fa);
        check("repl_evicted_miss", mi, 1);
        access(32'h0040_3010, 1, 0, 8'd3, pa, mi, fa);
        check("repl_way1_phys", pa, 32'hA000_1010);
        access(32'h0080_3010, 1, 0, 8'd3, pa, mi, fa);
        check("repl_way0_phys", pa, 32'hA000_2010);
        check("repl_way0_miss", mi, 0);

        // ASID match and global pages.
        upd(32'h0000_2000, 32'h8000_5000, 8'd3, 1, 0);
        access(32'h0000_2abc, 1, 0, 8'd3, pa, mi, fa);
        check("asid_phys", pa, 32'h8000_5abc);
        check("asid_miss", mi, 0);
        access(32'h0000_2abc, 1, 0, 8'd5, pa, mi, fa);
        check("asid_other_miss", mi, 1);
        check("asid_other_phys", pa, 32'h0000_2abc);
        inval(32'h0000_2000);
        upd(32'h0000_2000, 32'h8000_5000, 8'd3, 1, 1);
        access(32'h0000_2abc, 1, 0, 8'd5, pa, mi, fa);
        check("glb_phys", pa, 32'h8000_5abc);
        check("glb_miss", mi, 0);

        // Write permission.
        upd(32'h0000_6000, 32'h9000_6000, 8'd3, 0, 0);
        access(32'h0000_6123, 0, 1, 8'd3, pa, mi, fa);
        check("perm_fault", fa, 1);
        check("perm_no_miss", mi, 0);
        check("perm_miss_addr", miss_addr_o, 32'h0000_6123);
        access(32'h0000_6123, 1, 0, 8'd3, pa, mi, fa);
        check("perm_load_nofault", fa, 0);
        check("perm_load_phys", pa, 32'h9000_6123);

        // Invalidate a fully populated set.
        upd(32'h0000_8000, 32'hB000_0000, 8'd3, 1, 0);
        upd(32'h0040_8000, 32'hB000_1000, 8'd3, 1, 0);
        access(32'h0040_8004, 1, 0, 8'd3, pa, mi, fa);
        check("inval_pre_hit", pa, 32'hB000_1004);
        inval(32'h0000_8abc);
        access(32'h0000_8004, 1, 0, 8'd3, pa, mi, fa);
        check("inval_way_a_miss", mi, 1);
        access(32'h0040_8004, 1, 0, 8'd3, pa, mi, fa);
        check("inval_way_b_miss", mi, 1);

        // Stall holds the old translation across an update to the same set.
        upd(32'h0000_5000, 32'hC000_0000, 8'd3, 1, 0);
        address_x = 32'h0040_5abc; address_m = 32'h0040_5abc; load_q_m = 1; asid_i = 8'd3;
        tick();
        stall_m = 1; upd_i = 1; upd_vaddr_i = 32'h0040_5000; upd_paddr_i = 32'hC000_1000;
        upd_wr_i = 1; upd_glb_i = 0;
        tick();
        upd_i = 0;
        @(negedge clk_i);
        check("stall_hold_miss", miss_m, 1);
        tick();
        @(negedge clk_i);
        check("stall_hold_miss2", miss_m, 1);
        stall_m = 0;
        tick();
        @(negedge clk_i);
        check("stall_release_phys", physical_address_m, 32'hC000_1abc);
        check("stall_release_miss", miss_m, 0);
        tick();
        load_q_m = 0;

        // flush beats a same-cycle update; updates during flush are dropped.
        flush_i = 1; upd_i = 1; upd_vaddr_i = 32'h0000_9000; upd_paddr_i = 32'hD000_0000;
        tick();
        flush_i = 0; upd_i = 0;
        check("flush_busy_lit", busy_o, 1);
        tick();
        upd(32'h0000_7000, 32'hE000_0000, 8'd3, 1, 1);
        wait_idle();
        access(32'h0000_9000, 1, 0, 8'd3, pa, mi, fa);
        check("flush_wins_miss", mi, 1);
        access(32'h0000_7000, 1, 0, 8'd3, pa, mi, fa);
        check("busy_upd_dropped", mi, 1);
        access(32'h0040_5abc, 1, 0, 8'd3, pa, mi, fa);
        check("flush_cleared", mi, 1);

        // Random traffic over a few sets and tags so hits, multi-hits and faults all occur.
        for (int i = 0; i < 5000; i++) begin
            stall_m   = ($urandom_range(0, 4) == 0);
            enable_i  = ($urandom_range(0, 9) != 0);
            asid_i    = 8'($urandom_range(0, 3));
            address_x = ($urandom_range(0, 3) << 22) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 4095);
            address_m = ($urandom_range(0, 1) == 0) ? address_x :
                        (($urandom_range(0, 3) << 22) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 4095));
            load_q_m  = $urandom_range(0, 1);
            store_q_m = !load_q_m && $urandom_range(0, 1);
            upd_i       = ($urandom_range(0, 4) == 0);
            upd_vaddr_i = ($urandom_range(0, 3) << 22) | ($urandom_range(0, 3) << 12);
            upd_paddr_i = $urandom;
            upd_wr_i    = $urandom_range(0, 1);
            upd_glb_i   = ($urandom_range(0, 3) == 0);
            inval_i       = ($urandom_range(0, 19) == 0);
            inval_vaddr_i = $urandom_range(0, 3) << 12;
            flush_i       = ($urandom_range(0, 1999) == 0);
            tick();
        end
        upd_i = 0; inval_i = 0; flush_i = 0; load_q_m = 0; store_q_m = 0; stall_m = 0;
        wait_idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
